instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the single-issue MIPS core. Holds the PC and runs a req/ack handshake with instruction memory. Captures each returned word into an IF/ID register and presents it to decode through a valid/ready handshake; the `opCode` field of that register drives the main control decoder. Redirects from execute (taken `beq`) flush the stage and restart fetch at the target, and a request already in flight is dropped safely.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk` in 1: rising-edge clock.
- `resetN` in 1: reset, synchronous, active-low.
- `imem_req` out 1: instruction memory request.
- `imem_addr` out 32: word-aligned fetch address; stable while `imem_req`=1.
- `imem_ack` in 1: memory response valid; transfer occurs on an edge with `imem_req & imem_ack`.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `redirect` in 1: taken branch, one-cycle pulse.
- `redirect_pc` in 32: branch target; bits [1:0] ignored and forced to 0.
- `id_ready` in 1: decode accepts the IF/ID contents this cycle.
- `if_valid` out 1: IF/ID register holds a live instruction.
- `if_instr` out 32: fetched instruction.
- `if_opcode` out 6: `if_instr[31:26]`, feeds control `opCode`.
- `if_pc_plus4` out 32: fetch address + 4, for branch target computation.

## Operation
- FSM states: IDLE, REQ, FULL.
- IDLE: entered on reset. Lasts one cycle with `imem_req`=0, then moves to REQ.
- REQ: `imem_req`=1, `imem_addr`=pc.
  - On `imem_ack`: `if_instr`<=`imem_rdata`, `if_pc_plus4`<=pc+4, pc<=pc+4, `if_valid`<=1, next state FULL.
- FULL: `imem_req`=0. On `if_valid & id_ready`: `if_valid`<=0, next state REQ.
- Request rule: at most one outstanding request. Address and req are held until ack, and the memory never sees a withdrawn request.
- `redirect` has priority over every other event:
  - `if_valid`<=0, whatever the value of `id_ready`. Decode must not treat a redirect-cycle handshake as consumed.
  - In IDLE or FULL: pc<={`redirect_pc`[31:2],2'b00}, next state REQ.
  - In REQ with `imem_ack`=1 in the same cycle: discard the data, load pc from `redirect_pc`, stay in REQ.
  - In REQ with `imem_ack`=0: hold `imem_addr`, set `drop`, save the target in `redir_pc_q`. The next ack is discarded, `drop` clears, pc<=`redir_pc_q`, stay in REQ.
  - A second redirect while `drop`=1 overwrites `redir_pc_q`; the latest target wins.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset (`resetN`=0 at an edge): state IDLE, pc=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_opcode`=0, `if_pc_plus4`=0, `drop`=0, `redir_pc_q`=0.
- Reset mid-operation: an in-flight request is abandoned and `imem_ack` is ignored while `resetN`=0. Instruction memory shares `resetN` and must not ack stale requests after reset.
- First request: `imem_req` rises on the second edge after `resetN` goes high.
- Latency:
  - Ack at edge N gives `if_valid`=1 after edge N.
  - A handshake at edge M gives `imem_req`=1 after edge M.
  - Peak throughput is one instruction per two cycles with zero-wait memory.
- All outputs are registered. No combinational path from an input to any output.

## Structure
- Shared package `mips_pkg` holds:
  - `fetch_state_t` enum (IDLE, REQ, FULL).
  - Opcode constants `OP_RTYPE`=6'b000000, `OP_LW`=6'b100011, `OP_SW`=6'b101011, `OP_BEQ`=6'b000100, shared with control.
  - Default `RESET_PC`.
- Sub-module `if_id_reg`: the IF/ID capture register with load and flush inputs; outputs `if_valid`, `if_instr`, `if_pc_plus4`. The FSM, PC, `drop` and `redir_pc_q` stay in `instr_fetch`.

## Test plan
- Reset, zero-wait memory returning 32'h8C01_0004 at address 0, `id_ready`=1 → `imem_addr` sequence 0,4,8; `if_opcode`=6'b100011 and `if_pc_plus4`=4 after the first ack.
- Hold `id_ready`=0 for 5 cycles while FULL → `if_instr` stable, `imem_req`=0 throughout, fetch of address 4 starts the cycle after `id_ready` rises.
- Ack delayed 3 cycles, `redirect`=1 with `redirect_pc`=32'h40 on the second wait cycle → `imem_addr` stays at the old address until ack, ack data is discarded (`if_valid` stays 0), next request is to 32'h40.
- `redirect` to 32'h83 while FULL with `id_ready`=1 → `if_valid`=0 next cycle, next `imem_addr`=32'h80.
- `RESET_PC`=32'hFFFF_FFFC → second fetch address is 32'h0, and `if_pc_plus4`=0 for the first instruction.
- `resetN` pulled low for one cycle while in REQ, ack arriving in the same cycle → data ignored, `if_valid`=0, and fetch restarts at `RESET_PC` two edges after `resetN` rises.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: fetch FSM states, main opcodes and default reset PC.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: captures a fetched word on load, clears the valid bit on flush.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4
);

    logic        valid_d, valid_q;
    logic [31:0] instr_d, instr_q;
    logic [31:0] pc_plus4_d, pc_plus4_q;

    // Flush only kills the valid bit; stale data is harmless behind valid=0.
    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d    = 1'b1;
            instr_d    = instr_in;
            pc_plus4_d = pc_plus4_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            valid_q    <= 1'b0;
            instr_q    <= 32'h0;
            pc_plus4_q <= 32'h0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign if_valid    = valid_q;
    assign if_instr    = instr_q;
    assign if_pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem req/ack handshake and branch redirect.
//   state | meaning
//   IDLE  | post-reset settle, no request (one cycle after reset release)
//   REQ   | request to imem at pc outstanding; drop_q marks a redirected, stale request
//   FULL  | IF/ID holds a live instruction, waiting for decode to accept it
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        resetN,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [5:0]  if_opcode,
    output logic [31:0] if_pc_plus4
);

    fetch_state_t state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic [31:0]  redir_pc_d, redir_pc_q;
    logic         drop_d, drop_q;
    logic         warm_d, warm_q;
    logic         imem_req_d, imem_req_q;
    logic         ifid_load, ifid_flush;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redir_pc_d = redir_pc_q;
        drop_d     = drop_q;
        warm_d     = warm_q;
        ifid_load  = 1'b0;
        ifid_flush = redirect;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d    = word_align(redirect_pc);
                    state_d = REQ;
                end else if (warm_q) begin
                    state_d = REQ;
                end else begin
                    warm_d = 1'b1;
                end
            end
            REQ: begin
                if (redirect) begin
                    // Without an ack the address must stay put, so park the target.
                    if (imem_ack) begin
                        pc_d   = word_align(redirect_pc);
                        drop_d = 1'b0;
                    end else begin
                        drop_d     = 1'b1;
                        redir_pc_d = word_align(redirect_pc);
                    end
                end else if (imem_ack) begin
                    if (drop_q) begin
                        drop_d = 1'b0;
                        pc_d   = redir_pc_q;
                    end else begin
                        ifid_load = 1'b1;
                        pc_d      = pc_q + 32'd4;
                        state_d   = FULL;
                    end
                end
            end
            FULL: begin
                if (redirect) begin
                    pc_d    = word_align(redirect_pc);
                    state_d = REQ;
                end else if (id_ready) begin
                    ifid_flush = 1'b1;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        imem_req_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            redir_pc_q <= 32'h0;
            drop_q     <= 1'b0;
            warm_q     <= 1'b0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_pc_q <= redir_pc_d;
            drop_q     <= drop_d;
            warm_q     <= warm_d;
            imem_req_q <= imem_req_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .resetN      (resetN),
        .load        (ifid_load),
        .flush       (ifid_flush),
        .instr_in    (imem_rdata),
        .pc_plus4_in (pc_q + 32'd4),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc_plus4 (if_pc_plus4)
    );

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign if_opcode = if_instr[31:26];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run against a reference model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        resetN;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_instr, if_pc_plus4;
    logic [5:0]  if_opcode;

    logic        b_imem_req, b_if_valid;
    logic [31:0] b_imem_addr, b_if_instr, b_if_pc_plus4;
    logic [5:0]  b_if_opcode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .resetN(resetN), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .id_ready(id_ready), .if_valid(if_valid),
        .if_instr(if_instr), .if_opcode(if_opcode), .if_pc_plus4(if_pc_plus4)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .resetN(resetN), .imem_req(b_imem_req), .imem_addr(b_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .id_ready(id_ready), .if_valid(b_if_valid),
        .if_instr(b_if_instr), .if_opcode(b_if_opcode), .if_pc_plus4(b_if_pc_plus4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves both DUTs in REQ at their reset PC with all inputs idle.
    task automatic do_reset();
        resetN = 1'b0; imem_ack = 1'b0; redirect = 1'b0; id_ready = 1'b0;
        redirect_pc = 32'h0; imem_rdata = 32'h0;
        tick();
        resetN = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        resetN = 1'b0; imem_ack = 1'b1; redirect = 1'b0; id_ready = 1'b1;
        redirect_pc = 32'h0; imem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", if_instr); end
        checks++; if (if_opcode !== 6'h0) begin errors++; $display("FAIL rst_opcode got %h exp 0", if_opcode); end
        checks++; if (if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp 0", if_pc_plus4); end
        checks++; if (b_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_addr_b got %h exp fffffffc", b_imem_addr); end
        imem_ack = 1'b0;
        resetN = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h exp 0", imem_addr); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h8C01_0004; id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL zw_addr%0d got req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, 32'(4 * i)); end
            tick();
            checks++; if (if_valid !== 1'b1 || if_pc_plus4 !== 32'(4 * i + 4)) begin errors++; $display("FAIL zw_cap%0d got valid=%b pc4=%h exp valid=1 pc4=%h", i, if_valid, if_pc_plus4, 32'(4 * i + 4)); end
            checks++; if (if_opcode !== 6'b100011) begin errors++; $display("FAIL zw_opcode%0d got %b exp 100011", i, if_opcode); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_req_low%0d got %b exp 0", i, imem_req); end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h8C01_0004; id_ready = 1'b0;
        tick();
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d got %b exp 0", i, imem_req); end
            checks++; if (if_valid !== 1'b1 || if_instr !== 32'h8C01_0004) begin errors++; $display("FAIL stall_hold%0d got valid=%b instr=%h exp valid=1 instr=8c010004", i, if_valid, if_instr); end
        end
        id_ready = 1'b1; imem_ack = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL stall_resume got req=%b addr=%h exp req=1 addr=4", imem_req, imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stall_consumed got %b exp 0", if_valid); end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        id_ready = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL infl_hold1 got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL infl_hold2 got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'hABCD_0123;
        tick();
        imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL infl_discard got valid=%b exp 0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL infl_target got req=%b addr=%h exp req=1 addr=40", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h1000_0002;
        tick();
        imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_instr !== 32'h1000_0002 || if_pc_plus4 !== 32'h44) begin errors++; $display("FAIL infl_fetch got valid=%b instr=%h pc4=%h exp 1 10000002 44", if_valid, if_instr, if_pc_plus4); end
    endtask

    task automatic test_redirect_corner();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0020; id_ready = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h83; imem_ack = 1'b0;
        tick();
        redirect = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL full_redir_valid got %b exp 0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin errors++; $display("FAIL full_redir_addr got req=%b addr=%h exp req=1 addr=80", imem_req, imem_addr); end
        // two redirects while the request is pending: the later target wins
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0; imem_ack = 1'b1;
        tick();
        checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h200) begin errors++; $display("FAIL double_redir got valid=%b addr=%h exp valid=0 addr=200", if_valid, imem_addr); end
        // redirect coinciding with ack: data dropped, jump at once
        redirect = 1'b1; redirect_pc = 32'h301;
        tick();
        redirect = 1'b0; imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL ack_redir got valid=%b req=%b addr=%h exp 0 1 300", if_valid, imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        checks++; if (b_imem_req !== 1'b1 || b_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got req=%b addr=%h exp req=1 addr=fffffffc", b_imem_req, b_imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0000; id_ready = 1'b1;
        tick();
        checks++; if (b_if_valid !== 1'b1 || b_if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got valid=%b pc4=%h exp valid=1 pc4=0", b_if_valid, b_if_pc_plus4); end
        tick();
        checks++; if (b_imem_req !== 1'b1 || b_imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_second got req=%b addr=%h exp req=1 addr=0", b_imem_req, b_imem_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h8C01_0004; id_ready = 1'b1;
        tick();
        tick();
        imem_rdata = 32'h2222_3333;
        resetN = 1'b0;
        tick();
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL midrst got valid=%b req=%b addr=%h exp 0 0 0", if_valid, imem_req, imem_addr); end
        resetN = 1'b1; imem_ack = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midrst_idle got req=%b exp 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin errors++; $display("FAIL midrst_restart got req=%b addr=%h valid=%b exp 1 0 0", imem_req, imem_addr, if_valid); end
    endtask

    // Reference model: one pending fetch or one buffered instruction, plus an optional parked target.
    task automatic test_random();
        logic        m_fetching, m_valid, m_parked;
        logic [31:0] m_pc, m_target, m_instr, m_pc4;
        int          bad = 0;
        do_reset();
        m_fetching = 1'b1; m_valid = 1'b0; m_parked = 1'b0;
        m_pc = 32'h0; m_target = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            redirect    = ($urandom_range(0, 7) == 0);
            redirect_pc = $urandom;
            id_ready    = $urandom_range(0, 1);
            imem_ack    = m_fetching && ($urandom_range(0, 2) != 0);
            imem_rdata  = $urandom;
            if (redirect) begin
                m_valid = 1'b0;
                if (m_fetching && !imem_ack) begin
                    m_parked = 1'b1;
                    m_target = redirect_pc & 32'hFFFF_FFFC;
                end else begin
                    m_parked   = 1'b0;
                    m_pc       = redirect_pc & 32'hFFFF_FFFC;
                    m_fetching = 1'b1;
                end
            end else if (m_fetching && imem_ack) begin
                if (m_parked) begin
                    m_parked = 1'b0;
                    m_pc     = m_target;
                end else begin
                    m_valid    = 1'b1;
                    m_instr    = imem_rdata;
                    m_pc4      = m_pc + 32'd4;
                    m_pc       = m_pc + 32'd4;
                    m_fetching = 1'b0;
                end
            end else if (m_valid && id_ready) begin
                m_valid    = 1'b0;
                m_fetching = 1'b1;
            end
            tick();
            checks++;
            if (imem_req !== m_fetching || imem_addr !== m_pc || if_valid !== m_valid ||
                (m_valid && (if_instr !== m_instr || if_pc_plus4 !== m_pc4 || if_opcode !== m_instr[31:26]))) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL rand_cyc%0d got req=%b addr=%h valid=%b instr=%h pc4=%h exp req=%b addr=%h valid=%b instr=%h pc4=%h",
                             cyc, imem_req, imem_addr, if_valid, if_instr, if_pc_plus4,
                             m_fetching, m_pc, m_valid, m_instr, m_pc4);
            end
        end
        redirect = 1'b0; imem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_inflight();
        test_redirect_corner();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
